// File: rtl/wbc_cmd_master.sv
// wbc_cmd_master
// Classic (non-pipelined) Wishbone bus master driven by a single-word
// valid/ready command port. Each accepted command becomes one Wishbone
// read or write cycle. The result goes back on a valid/ready response port.
// Only one transaction is outstanding at a time. A bounded timeout ends any
// cycle that a slave never acknowledges.
//
// Parameters:
//   AW      Wishbone word-address width
//   DW      data width (DW/8 byte selects)
//   TIMEOUT max cycles cyc may stay high without ack/err (0 = never time out)
//
// Ports:
//   i_clk, i_reset                      clock, async active-high reset
//   i_cmd_valid / o_cmd_ready           command handshake
//   i_cmd_we/addr/data/sel              command payload
//   o_rsp_valid / i_rsp_ready           response handshake
//   o_rsp_data, o_rsp_status            read data (0 for writes/failures);
//                                       status 00 ok, 01 bus error, 10 timeout
//   o_wb_cyc/stb/we/adr/dat/sel         Wishbone master outputs
//   i_wb_ack/err/dat                    Wishbone slave returns
//   o_busy                              high whenever not idle
module wbc_cmd_master #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_we,
  input  logic [AW-1:0]     i_cmd_addr,
  input  logic [DW-1:0]     i_cmd_data,
  input  logic [DW/8-1:0]   i_cmd_sel,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DW-1:0]     o_rsp_data,
  output logic [1:0]        o_rsp_status,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [AW-1:0]     o_wb_adr,
  output logic [DW-1:0]     o_wb_dat,
  output logic [DW/8-1:0]   o_wb_sel,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  input  logic [DW-1:0]     i_wb_dat,
  output logic              o_busy
);

  localparam int SW = DW / 8;
  // A disabled timeout still gets a 1-bit counter so the vector stays legal.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST_INT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST_INT);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BUS_ERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;

  assign o_busy = (state_reg != S_IDLE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      o_cmd_ready  <= 1'b0;
      o_rsp_valid  <= 1'b0;
      o_rsp_data   <= '0;
      o_rsp_status <= ST_OK;
      o_wb_cyc     <= 1'b0;
      o_wb_stb     <= 1'b0;
      o_wb_we      <= 1'b0;
      o_wb_adr     <= '0;
      o_wb_dat     <= '0;
      o_wb_sel     <= {SW{1'b0}};
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (o_cmd_ready && i_cmd_valid) begin
            o_wb_we     <= i_cmd_we;
            o_wb_adr    <= i_cmd_addr;
            o_wb_dat    <= i_cmd_data;
            o_wb_sel    <= i_cmd_sel;
            o_wb_cyc    <= 1'b1;
            o_wb_stb    <= 1'b1;
            cnt_reg     <= '0;
            o_cmd_ready <= 1'b0;
            state_reg   <= S_BUS;
          end else begin
            // Ready comes up one edge after reset release and stays up
            // until a command is taken.
            o_cmd_ready <= 1'b1;
          end
        end

        S_BUS: begin
          if (i_wb_err || i_wb_ack ||
              ((TIMEOUT != 0) && (cnt_reg == CNT_LAST))) begin
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_rsp_valid <= 1'b1;
            state_reg   <= S_RESP;
            // Error wins over a simultaneous ack.
            if (i_wb_err) begin
              o_rsp_status <= ST_BUS_ERR;
              o_rsp_data   <= '0;
            end else if (i_wb_ack) begin
              o_rsp_status <= ST_OK;
              o_rsp_data   <= o_wb_we ? '0 : i_wb_dat;
            end else begin
              o_rsp_status <= ST_TIMEOUT;
              o_rsp_data   <= '0;
            end
          end else if (cnt_reg != CNT_MAX) begin
            // Saturating so a disabled timeout can never wrap into a match.
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        S_RESP: begin
          // Stray ack/err here are simply not looked at.
          if (i_rsp_ready) begin
            o_rsp_valid  <= 1'b0;
            o_rsp_data   <= '0;
            o_rsp_status <= ST_OK;
            o_cmd_ready  <= 1'b1;
            state_reg    <= S_IDLE;
          end
        end

        default: begin
          state_reg   <= S_IDLE;
          o_cmd_ready <= 1'b0;
          o_rsp_valid <= 1'b0;
          o_wb_cyc    <= 1'b0;
          o_wb_stb    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbc_cmd_master.sv
// Directed testbench for wbc_cmd_master (TIMEOUT overridden to 8).
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, half a period after the active rising edge.
module tb_wbc_cmd_master;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [SW-1:0] cmd_sel = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_status;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat;
  logic [SW-1:0] wb_sel;
  logic          ack_drv = 1'b0;
  logic          err_drv = 1'b0;
  logic          auto_ack = 1'b0;
  logic          wb_ack;
  logic [DW-1:0] wb_rdat = '0;
  logic          busy;

  // auto_ack models a zero-wait combinational slave.
  assign wb_ack = ack_drv | (auto_ack & wb_stb);

  int n_cmp = 0;
  int n_bad = 0;

  logic          exp_we;
  logic [AW-1:0] exp_adr;
  logic [DW-1:0] exp_dat;
  logic [SW-1:0] exp_sel;

  always #5 clk = ~clk;

  wbc_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_we     (cmd_we),
    .i_cmd_addr   (cmd_addr),
    .i_cmd_data   (cmd_data),
    .i_cmd_sel    (cmd_sel),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_rsp_status (rsp_status),
    .o_wb_cyc     (wb_cyc),
    .o_wb_stb     (wb_stb),
    .o_wb_we      (wb_we),
    .o_wb_adr     (wb_adr),
    .o_wb_dat     (wb_dat),
    .o_wb_sel     (wb_sel),
    .i_wb_ack     (wb_ack),
    .i_wb_err     (err_drv),
    .i_wb_dat     (wb_rdat),
    .o_busy       (busy)
  );

  // Present a command at a falling edge; it is taken on the next rising edge.
  task automatic issue(input logic we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat, input logic [SW-1:0] sel,
                       input bit hold);
    cmd_we = we; cmd_addr = adr; cmd_data = dat; cmd_sel = sel;
    exp_we = we; exp_adr = adr; exp_dat = dat; exp_sel = sel;
    cmd_valid = 1'b1;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Slave model: acks (optionally with err) in the ack_at-th cyc cycle;
  // ack_at = 0 means silent. Reports cyc-high cycles and field stability.
  task automatic drive_bus(input int ack_at, input logic with_err,
                           input logic [DW-1:0] rdata,
                           output int cyc_cycles, output bit stable);
    cyc_cycles = 0;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!wb_cyc) break;
      cyc_cycles++;
      if (wb_stb !== 1'b1 || wb_we !== exp_we || wb_adr !== exp_adr ||
          wb_dat !== exp_dat || wb_sel !== exp_sel) stable = 1'b0;
      if (ack_at != 0 && cyc_cycles == ack_at) begin
        ack_drv = 1'b1; err_drv = with_err; wb_rdat = rdata;
      end else begin
        ack_drv = 1'b0; err_drv = 1'b0; wb_rdat = 32'h5555_AAAA;
      end
      @(negedge clk);
    end
    ack_drv = 1'b0;
    err_drv = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_dat, wb_sel} !== '0) begin n_bad++; $display("FAIL reset_wb: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h want all 0", wb_cyc, wb_stb, wb_we, wb_adr, wb_dat, wb_sel); end
    n_cmp++; if ({rsp_valid, rsp_data, rsp_status, busy, cmd_ready} !== '0) begin n_bad++; $display("FAIL reset_rsp: got valid=%b data=%h status=%b busy=%b ready=%b want all 0", rsp_valid, rsp_data, rsp_status, busy, cmd_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
    $display("reset: done");
  endtask

  task automatic test_write();
    int cc; bit st;
    issue(1'b1, 30'h0800_0000, 32'h0000_000F, 4'hF, 1'b0);
    n_cmp++; if ({wb_cyc, wb_stb, busy, cmd_ready} !== 4'b1110) begin n_bad++; $display("FAIL write_start: got cyc/stb/busy/ready=%b%b%b%b want 1110", wb_cyc, wb_stb, busy, cmd_ready); end
    drive_bus(3, 1'b0, 32'hCAFE_F00D, cc, st);
    n_cmp++; if (cc !== 3) begin n_bad++; $display("FAIL write_cyc_len: got %0d want 3", cc); end
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL write_stable: got %b want 1", st); end
    n_cmp++; if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, 2'b00, 32'h0}) begin n_bad++; $display("FAIL write_rsp: got valid=%b status=%b data=%h want 1/00/00000000", rsp_valid, rsp_status, rsp_data); end
    consume();
    n_cmp++; if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin n_bad++; $display("FAIL write_consume: got valid/ready/busy=%b%b%b want 010", rsp_valid, cmd_ready, busy); end
    $display("write: adr=%h dat=%h cyc_cycles=%0d status=%b", exp_adr, exp_dat, cc, 2'b00);
  endtask

  task automatic test_read();
    int cc; bit st;
    issue(1'b0, 30'h0400_0001, 32'h0, 4'hF, 1'b0);
    drive_bus(1, 1'b0, 32'hDEAD_BEEF, cc, st);
    n_cmp++; if (cc !== 1) begin n_bad++; $display("FAIL read_cyc_len: got %0d want 1", cc); end
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL read_stable: got %b want 1", st); end
    n_cmp++; if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, 2'b00, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL read_rsp: got valid=%b status=%b data=%h want 1/00/deadbeef", rsp_valid, rsp_status, rsp_data); end
    consume();
    $display("read: adr=%h data=%h cyc_cycles=%0d", exp_adr, rsp_data, cc);
  endtask

  task automatic test_error();
    int cc; bit st;
    issue(1'b0, 30'h0000_0010, 32'h0, 4'h3, 1'b0);
    drive_bus(2, 1'b1, 32'h1234_5678, cc, st);
    n_cmp++; if (cc !== 2) begin n_bad++; $display("FAIL err_cyc_len: got %0d want 2", cc); end
    n_cmp++; if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, 2'b01, 32'h0}) begin n_bad++; $display("FAIL err_rsp: got valid=%b status=%b data=%h want 1/01/00000000", rsp_valid, rsp_status, rsp_data); end
    consume();
    $display("error: adr=%h cyc_cycles=%0d", exp_adr, cc);
  endtask

  task automatic test_timeout();
    int cc; bit st;
    issue(1'b0, 30'h0000_0020, 32'h0, 4'hF, 1'b0);
    drive_bus(0, 1'b0, 32'h0, cc, st);
    n_cmp++; if (cc !== TO) begin n_bad++; $display("FAIL timeout_cyc_len: got %0d want %0d", cc, TO); end
    n_cmp++; if ({rsp_valid, rsp_status, rsp_data, busy} !== {1'b1, 2'b10, 32'h0, 1'b1}) begin n_bad++; $display("FAIL timeout_rsp: got valid=%b status=%b data=%h busy=%b want 1/10/00000000/1", rsp_valid, rsp_status, rsp_data, busy); end
    consume();
    $display("timeout: adr=%h cyc_cycles=%0d", exp_adr, cc);
    // Next command must start with a cleared counter.
    issue(1'b1, 30'h0000_0024, 32'h0BAD_CAFE, 4'hC, 1'b0);
    drive_bus(5, 1'b0, 32'h0, cc, st);
    n_cmp++; if (cc !== 5) begin n_bad++; $display("FAIL post_timeout_cyc_len: got %0d want 5", cc); end
    n_cmp++; if ({rsp_valid, rsp_status} !== 3'b100) begin n_bad++; $display("FAIL post_timeout_rsp: got valid=%b status=%b want 1/00", rsp_valid, rsp_status); end
    consume();
    $display("post-timeout write: adr=%h cyc_cycles=%0d", exp_adr, cc);
  endtask

  task automatic test_backpressure();
    int cc; bit st;
    issue(1'b0, 30'h0400_0002, 32'h0, 4'hF, 1'b1);
    // Valid stays high with a different command queued behind the read.
    cmd_we = 1'b1; cmd_addr = 30'h0800_0004; cmd_data = 32'h1357_9BDF; cmd_sel = 4'h1;
    drive_bus(1, 1'b0, 32'hA5A5_A5A5, cc, st);
    n_cmp++; if (cc !== 1) begin n_bad++; $display("FAIL bp_cyc_len: got %0d want 1", cc); end
    for (int k = 0; k < 5; k++) begin
      ack_drv = (k == 2);
      @(negedge clk);
      n_cmp++; if ({rsp_valid, rsp_data, rsp_status, cmd_ready, wb_cyc} !== {1'b1, 32'hA5A5_A5A5, 2'b00, 1'b0, 1'b0}) begin n_bad++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h status=%b ready=%b cyc=%b want 1/a5a5a5a5/00/0/0", k, rsp_valid, rsp_data, rsp_status, cmd_ready, wb_cyc); end
    end
    ack_drv = 1'b0;
    exp_we = 1'b1; exp_adr = 30'h0800_0004; exp_dat = 32'h1357_9BDF; exp_sel = 4'h1;
    consume();
    n_cmp++; if ({rsp_valid, cmd_ready, wb_cyc} !== 3'b010) begin n_bad++; $display("FAIL bp_handshake: got valid/ready/cyc=%b%b%b want 010", rsp_valid, cmd_ready, wb_cyc); end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++; if ({wb_cyc, wb_we, wb_adr, wb_dat, wb_sel} !== {1'b1, 1'b1, 30'h0800_0004, 32'h1357_9BDF, 4'h1}) begin n_bad++; $display("FAIL bp_next_cycle: got cyc=%b we=%b adr=%h dat=%h sel=%h want 1/1/08000004/13579bdf/1", wb_cyc, wb_we, wb_adr, wb_dat, wb_sel); end
    drive_bus(1, 1'b0, 32'h0, cc, st);
    consume();
    $display("backpressure: held 5 cycles, next adr=%h cyc_cycles=%0d", exp_adr, cc);
  endtask

  task automatic test_back_to_back();
    int n_cyc = 0;
    int n_rsp = 0;
    cmd_we = 1'b0; cmd_addr = 30'h0000_0100; cmd_data = '0; cmd_sel = 4'hF;
    wb_rdat = 32'h0000_0042;
    auto_ack = 1'b1; rsp_ready = 1'b1; cmd_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (wb_cyc) n_cyc++;
      if (rsp_valid) n_rsp++;
    end
    cmd_valid = 1'b0; auto_ack = 1'b0; rsp_ready = 1'b0;
    n_cmp++; if (n_cyc !== 4) begin n_bad++; $display("FAIL b2b_cycles: got %0d want 4", n_cyc); end
    n_cmp++; if (n_rsp !== 4) begin n_bad++; $display("FAIL b2b_responses: got %0d want 4", n_rsp); end
    @(negedge clk);
    n_cmp++; if ({busy, cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL b2b_idle: got busy/ready=%b%b want 01", busy, cmd_ready); end
    $display("back_to_back: %0d transactions in 12 cycles", n_rsp);
  endtask

  task automatic test_reset_mid_bus();
    issue(1'b1, 30'h0000_0200, 32'hFFFF_0000, 4'hF, 1'b0);
    @(negedge clk);
    n_cmp++; if (wb_cyc !== 1'b1) begin n_bad++; $display("FAIL mid_bus_cyc: got %b want 1", wb_cyc); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_dat, wb_sel, rsp_valid, rsp_data, rsp_status, busy, cmd_ready} !== '0) begin n_bad++; $display("FAIL mid_bus_async_clear: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h rv=%b rd=%h rs=%b busy=%b ready=%b want all 0", wb_cyc, wb_stb, wb_we, wb_adr, wb_dat, wb_sel, rsp_valid, rsp_data, rsp_status, busy, cmd_ready); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({cmd_ready, wb_cyc, rsp_valid} !== 3'b100) begin n_bad++; $display("FAIL mid_bus_release: got ready/cyc/rv=%b%b%b want 100", cmd_ready, wb_cyc, rsp_valid); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL mid_bus_no_rsp: got rv/busy=%b%b want 00", rsp_valid, busy); end
    $display("reset_mid_bus: transaction discarded");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_error();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_bus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
